// File: rtl/wm_pkg.sv
// Shared types for the washing-machine program controller: stage and mode
// encodings plus the helper that turns a stage and program into a timer load.
package wm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_FILL  = 3'b001,
    ST_WASH  = 3'b010,
    ST_DRAIN = 3'b011,
    ST_RINSE = 3'b100,
    ST_SPIN  = 3'b101,
    ST_DONE  = 3'b110
  } stage_e;

  typedef enum logic [1:0] {
    MODE_QUICK  = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_HEAVY  = 2'd2,
    MODE_ALT    = 2'd3
  } mode_e;

  // The spare panel code runs the NORMAL program.
  function automatic mode_e norm_mode(input logic [1:0] m);
    if (m == 2'd3) begin
      return MODE_NORMAL;
    end else begin
      return mode_e'(m);
    end
  endfunction

  // Timer load for a stage: base duration times (mode+1), minus one because
  // the stage also spends the cycle in which the timer reads zero.
  function automatic int unsigned stage_load(
    input stage_e      st,
    input mode_e       m,
    input int unsigned t_fill,
    input int unsigned t_wash,
    input int unsigned t_drain,
    input int unsigned t_rinse,
    input int unsigned t_spin
  );
    int unsigned base;
    int unsigned k;
    k = 32'(m) + 32'd1;
    case (st)
      ST_FILL:  base = t_fill;
      ST_WASH:  base = t_wash;
      ST_DRAIN: base = t_drain;
      ST_RINSE: base = t_rinse;
      ST_SPIN:  base = t_spin;
      default:  base = 32'd0;
    endcase
    if (base == 32'd0) begin
      return 32'd0;
    end else begin
      return (base * k) - 32'd1;
    end
  endfunction

endpackage

// File: rtl/wm_program_ctrl_if.sv
// Front-panel / driver bundle of the washing-machine program controller.
interface wm_program_ctrl_if;
  logic       cycle;
  logic       supply;
  logic [1:0] mode;
  logic       abort;
  logic [2:0] stage;
  logic       door_lock;
  logic       paused;
  logic       done;

  modport master (
    output cycle, supply, mode, abort,
    input  stage, door_lock, paused, done
  );

  modport slave (
    input  cycle, supply, mode, abort,
    output stage, door_lock, paused, done
  );
endinterface

// File: rtl/wm_stage_timer.sv
// Per-stage down-counter: load has priority, decrements while enabled and
// parks at zero so an idle machine never wraps.
module wm_stage_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign zero = (cnt_q == {CNT_W{1'b0}});

  // Next count: load, else decrement when running and not yet expired.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wm_program_ctrl.sv
// Washing-machine program sequencer: FILL/WASH/DRAIN/RINSE/SPIN with scaled
// stage timers, rinse passes, supply-loss pause and abort to drain.
module wm_program_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned T_FILL  = 20,
  parameter int unsigned T_WASH  = 60,
  parameter int unsigned T_DRAIN = 15,
  parameter int unsigned T_RINSE = 30,
  parameter int unsigned T_SPIN  = 40,
  parameter int unsigned RINSES  = 2
) (
  input logic              clk,
  input logic              rst,
  wm_program_ctrl_if.slave bus
);
  import wm_pkg::*;

  localparam int unsigned RC_W = $clog2(RINSES + 2);

  stage_e           stage_q, stage_d;
  mode_e            mode_q, mode_d;
  logic [RC_W-1:0]  rinse_q, rinse_d;
  logic             abort_pend_q, abort_pend_d;
  logic             door_lock_q, door_lock_d;
  logic             done_q, done_d;
  logic [RC_W-1:0]  rinse_total;
  logic             tmr_load;
  logic             tmr_zero;
  logic [CNT_W-1:0] tmr_load_val;

  // HEAVY adds one extra rinse pass.
  always_comb begin
    if (mode_q == MODE_HEAVY) begin
      rinse_total = RC_W'(RINSES + 1);
    end else begin
      rinse_total = RC_W'(RINSES);
    end
  end

  // Next-state logic; everything holds while supply is absent.
  always_comb begin
    stage_d      = stage_q;
    mode_d       = mode_q;
    rinse_d      = rinse_q;
    abort_pend_d = abort_pend_q;
    tmr_load     = 1'b0;
    if (bus.supply) begin
      case (stage_q)
        ST_IDLE: begin
          if (bus.cycle) begin
            stage_d      = ST_FILL;
            mode_d       = norm_mode(bus.mode);
            rinse_d      = {RC_W{1'b0}};
            abort_pend_d = 1'b0;
            tmr_load     = 1'b1;
          end else begin
            stage_d = ST_IDLE;
          end
        end
        ST_FILL, ST_WASH, ST_RINSE: begin
          // Abort beats a coincident timer expiry.
          if (bus.abort) begin
            stage_d      = ST_DRAIN;
            abort_pend_d = 1'b1;
            tmr_load     = 1'b1;
          end else if (tmr_zero) begin
            tmr_load = 1'b1;
            if (stage_q == ST_FILL) begin
              stage_d = ST_WASH;
            end else if (stage_q == ST_WASH) begin
              stage_d = ST_DRAIN;
            end else begin
              stage_d = ST_DRAIN;
              rinse_d = rinse_q + RC_W'(1);
            end
          end else begin
            stage_d = stage_q;
          end
        end
        ST_DRAIN: begin
          abort_pend_d = abort_pend_q | bus.abort;
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (abort_pend_q || bus.abort) begin
              stage_d = ST_DONE;
            end else if (rinse_q < rinse_total) begin
              stage_d = ST_RINSE;
            end else begin
              stage_d = ST_SPIN;
            end
          end else begin
            stage_d = ST_DRAIN;
          end
        end
        ST_SPIN: begin
          if (tmr_zero) begin
            stage_d = ST_DONE;
          end else begin
            stage_d = ST_SPIN;
          end
        end
        ST_DONE: begin
          stage_d = ST_IDLE;
        end
        default: begin
          stage_d = ST_IDLE;
        end
      endcase
    end else begin
      stage_d = stage_q;
    end
  end

  // Outputs are decoded from the next stage so they register with it.
  always_comb begin
    door_lock_d  = (stage_d != ST_IDLE) && (stage_d != ST_DONE);
    done_d       = (stage_d == ST_DONE);
    tmr_load_val = CNT_W'(stage_load(stage_d, mode_d, T_FILL, T_WASH,
                                     T_DRAIN, T_RINSE, T_SPIN));
  end

  // State, latched program and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q      <= ST_IDLE;
      mode_q       <= MODE_NORMAL;
      rinse_q      <= {RC_W{1'b0}};
      abort_pend_q <= 1'b0;
      door_lock_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      mode_q       <= mode_d;
      rinse_q      <= rinse_d;
      abort_pend_q <= abort_pend_d;
      door_lock_q  <= door_lock_d;
      done_q       <= done_d;
    end
  end

  wm_stage_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (bus.supply),
    .zero     (tmr_zero)
  );

  assign bus.stage     = stage_q;
  assign bus.door_lock = door_lock_q;
  assign bus.done      = done_q;
  // Follows mains directly so the panel shows a pause the moment power drops.
  assign bus.paused    = ~bus.supply & (stage_q != ST_IDLE);

endmodule

// File: tb/tb_wm_program_ctrl.sv
// Directed bench for wm_program_ctrl with short stage durations.
module tb_wm_program_ctrl;

  logic clk;
  logic rst;
  int   checks_cnt;
  int   errors_cnt;
  int   lock_bad;

  wm_program_ctrl_if bus ();

  wm_program_ctrl #(
    .CNT_W(16), .T_FILL(2), .T_WASH(4), .T_DRAIN(2),
    .T_RINSE(3), .T_SPIN(4), .RINSES(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int exp_st1[6]  = '{1, 2, 3, 4, 3, 5};
  int exp_len1[6] = '{2, 4, 2, 3, 2, 4};
  int exp_st2[8]  = '{1, 2, 3, 4, 3, 4, 3, 5};
  int exp_len2[8] = '{6, 12, 6, 9, 6, 9, 6, 12};

  task automatic check_eq(input string tag, input int act, input int exp);
    checks_cnt++;
    if (act != exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] m);
    bus.mode   = m;
    bus.cycle  = 1'b1;
    bus.supply = 1'b1;
    step();
    bus.cycle  = 1'b0;
    check_eq("start_fill", int'(bus.stage), 1);
  endtask

  // Length of the stage currently shown, sampled once per cycle.
  task automatic measure(output int st, output int len);
    st  = int'(bus.stage);
    len = 0;
    while (int'(bus.stage) == st && len < 200) begin
      if (!bus.door_lock) lock_bad = 1;
      len++;
      step();
    end
  endtask

  task automatic wait_stage(input int st, input int bound, input string tag);
    int n;
    n = 0;
    while (int'(bus.stage) != st && n < bound) begin
      step();
      n++;
    end
    check_eq(tag, int'(bus.stage), st);
  endtask

  initial begin
    int st;
    int len;
    int total;
    checks_cnt = 0;
    errors_cnt = 0;
    lock_bad   = 0;
    rst        = 1'b1;
    bus.cycle  = 1'b0;
    bus.supply = 1'b1;
    bus.mode   = 2'd0;
    bus.abort  = 1'b0;
    step();
    step();
    check_eq("rst_stage", int'(bus.stage), 0);
    check_eq("rst_lock", int'(bus.door_lock), 0);
    check_eq("rst_paused", int'(bus.paused), 0);
    check_eq("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    step();

    // 1: QUICK program, uninterrupted
    start(2'd0);
    total = 0;
    for (int i = 0; i < 6; i++) begin
      measure(st, len);
      check_eq("t1_stage", st, exp_st1[i]);
      check_eq("t1_len", len, exp_len1[i]);
      total += len;
    end
    check_eq("t1_total", total, 17);
    check_eq("t1_done_stage", int'(bus.stage), 6);
    check_eq("t1_done", int'(bus.done), 1);
    check_eq("t1_done_lock", int'(bus.door_lock), 0);
    step();
    check_eq("t1_idle", int'(bus.stage), 0);
    check_eq("t1_done_drop", int'(bus.done), 0);

    // 2: HEAVY program, extra rinse and tripled durations
    lock_bad = 0;
    start(2'd2);
    for (int i = 0; i < 8; i++) begin
      measure(st, len);
      check_eq("t2_stage", st, exp_st2[i]);
      check_eq("t2_len", len, exp_len2[i]);
    end
    check_eq("t2_lock", lock_bad, 0);
    check_eq("t2_done", int'(bus.stage), 6);
    step();

    // 3: NORMAL, supply loss mid-WASH; mode change after start ignored
    start(2'd1);
    bus.mode = 2'd0;
    measure(st, len);
    check_eq("t3_fill_len", len, 4);
    check_eq("t3_wash", int'(bus.stage), 2);
    step();
    step();
    step();
    bus.supply = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check_eq("t3_frozen", int'(bus.stage), 2);
    check_eq("t3_paused", int'(bus.paused), 1);
    check_eq("t3_lock", int'(bus.door_lock), 1);
    bus.supply = 1'b1;
    #1;
    check_eq("t3_unpaused", int'(bus.paused), 0);
    measure(st, len);
    check_eq("t3_wash_rest", len, 5);
    check_eq("t3_drain", int'(bus.stage), 3);
    wait_stage(0, 300, "t3_finish");

    // 4a: abort in WASH goes to a short DRAIN and then DONE
    start(2'd0);
    measure(st, len);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_eq("t4_abort_drain", int'(bus.stage), 3);
    measure(st, len);
    check_eq("t4_drain_len", len, 2);
    check_eq("t4_no_spin", int'(bus.stage), 6);
    step();

    // 4b: abort in DRAIN lets the drain finish, then DONE
    start(2'd0);
    wait_stage(3, 50, "t4b_drain");
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    measure(st, len);
    check_eq("t4b_drain_rest", len, 1);
    check_eq("t4b_done", int'(bus.stage), 6);
    step();

    // 4c: abort while supply is absent is ignored
    start(2'd1);
    measure(st, len);
    bus.supply = 1'b0;
    bus.abort  = 1'b1;
    step();
    step();
    step();
    check_eq("t4c_ignored", int'(bus.stage), 2);
    bus.abort  = 1'b0;
    bus.supply = 1'b1;
    measure(st, len);
    check_eq("t4c_wash_len", len, 8);
    wait_stage(0, 300, "t4c_finish");

    // 5: asynchronous reset in RINSE, then no start without supply
    start(2'd0);
    wait_stage(4, 50, "t5_rinse");
    #3;
    rst = 1'b1;
    #1;
    check_eq("t5_async_stage", int'(bus.stage), 0);
    check_eq("t5_async_lock", int'(bus.door_lock), 0);
    step();
    rst = 1'b0;
    bus.cycle  = 1'b1;
    bus.supply = 1'b0;
    step();
    step();
    step();
    check_eq("t5_no_start", int'(bus.stage), 0);
    check_eq("t5_idle_paused", int'(bus.paused), 0);
    bus.cycle  = 1'b0;
    bus.supply = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
